tt_ram_ctrl_seq: RTL and testbench

- Digital access sequencer that drives the SRAM test column in front of the analog RAM differential sense amplifier.
- Accepts single-bit read/write commands from the dedicated input pins.
- Generates non-overlapping precharge / wordline / write-drive / sense-enable phases with a one-hot wordline.
- Latches the digitised sense-amp decision and reports it on the output pins.

---
 rtl/tt_ram_ctrl_pkg.sv | 43 ++++
 rtl/tt_ram_ctrl_sync.sv | 32 +++
 rtl/tt_ram_ctrl_seq.sv | 196 +++++++++++++++++++
 tb/tb_tt_ram_ctrl_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_ram_ctrl_pkg.sv
// Shared types and constants for the RAM test-column access sequencer.
// Optional macro RAM_CTRL_SENSE_VOTE_EN selects 2-of-3 sense voting in tt_ram_ctrl_seq.
package tt_ram_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_WL    = 3'd2,
        ST_SENSE = 3'd3,
        ST_WRITE = 3'd4,
        ST_REC   = 3'd5
    } state_e;

    // uo_out bit positions
    localparam int UO_PRE   = 0;
    localparam int UO_SENSE = 1;
    localparam int UO_WRITE = 2;
    localparam int UO_BL    = 3;
    localparam int UO_BUSY  = 4;
    localparam int UO_RDV   = 5;
    localparam int UO_RDATA = 6;
    localparam int UO_DROP  = 7;

    // ui_in field positions
    localparam int UI_START  = 0;
    localparam int UI_WE     = 1;
    localparam int UI_WDATA  = 2;
    localparam int UI_ADDR_L = 3;
    localparam int UI_ADDR_H = 5;
    localparam int UI_SENSE  = 6;

    // Counter is loaded with length-1 so a phase lasts exactly len cycles.
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tt_ram_ctrl_sync.sv
// Two-flop synchroniser for the 6-bit command field plus a rising-edge
// detect on bit 0 (start) against a registered copy of the synchronised bit.
module tt_ram_ctrl_sync
    import tt_ram_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] d_i,
    output logic [5:0] q_o,
    output logic       rise_o
);

    logic [5:0] meta_q;
    logic [5:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q[UI_START];
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q[UI_START] & ~prev_q;

endmodule

// File: rtl/tt_ram_ctrl_seq.sv
// Access sequencer for the SRAM test column: precharge / wordline / sense / write
// phases with a one-hot wordline. Macro RAM_CTRL_SENSE_VOTE_EN enables 2-of-3 sense voting.
module tt_ram_ctrl_seq
    import tt_ram_ctrl_pkg::*;
#(
    parameter int unsigned T_PRE   = 4,
    parameter int unsigned T_WL    = 2,
    parameter int unsigned T_SENSE = 4,
    parameter int unsigned T_WR    = 4,
    parameter int unsigned T_REC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         cmd_sync;
    logic               start_rise;
    logic               sense_meta_q, sense_q;
    logic               we_q, wdata_q;
    logic [2:0]         addr_q;
    logic               rdata_q, rdv_q, dropped_q;
    logic               rdata_next;
    logic               accept, phase_done, sense_last;
    logic               pre_en, sense_en, write_en, bl_drive;
    logic [7:0]         wordline;

    logic unused_inputs;
    assign unused_inputs = ^{ui_in[7], uio_in};

    tt_ram_ctrl_sync u_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (ui_in[5:0]),
        .q_o    (cmd_sync),
        .rise_o (start_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sense_meta_q <= 1'b0;
            sense_q      <= 1'b0;
        end else begin
            sense_meta_q <= ui_in[UI_SENSE];
            sense_q      <= sense_meta_q;
        end
    end

    assign accept     = (state_q == ST_IDLE) && start_rise && ena;
    assign phase_done = (cnt_q == '0);
    assign sense_last = (state_q == ST_SENSE) && phase_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = phase_done ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PRE;
                    cnt_d   = phase_load(T_PRE);
                end
            end
            ST_PRE: begin
                if (phase_done) begin
                    if (we_q) begin
                        state_d = ST_WRITE;
                        cnt_d   = phase_load(T_WR);
                    end else begin
                        state_d = ST_WL;
                        cnt_d   = phase_load(T_WL);
                    end
                end
            end
            ST_WL: begin
                if (phase_done) begin
                    state_d = ST_SENSE;
                    cnt_d   = phase_load(T_SENSE);
                end
            end
            ST_SENSE, ST_WRITE: begin
                if (phase_done) begin
                    state_d = ST_REC;
                    cnt_d   = phase_load(T_REC);
                end
            end
            ST_REC: begin
                if (phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Drives are pure decodes of the state so reset clears them without a clock.
    always_comb begin
        pre_en   = 1'b0;
        sense_en = 1'b0;
        write_en = 1'b0;
        bl_drive = 1'b0;
        wordline = '0;
        case (state_q)
            ST_PRE:   pre_en = 1'b1;
            ST_WL:    wordline = 8'b1 << addr_q;
            ST_SENSE: begin
                wordline = 8'b1 << addr_q;
                sense_en = 1'b1;
            end
            ST_WRITE: begin
                wordline = 8'b1 << addr_q;
                write_en = 1'b1;
                bl_drive = wdata_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        uo_out           = '0;
        uo_out[UO_PRE]   = pre_en;
        uo_out[UO_SENSE] = sense_en;
        uo_out[UO_WRITE] = write_en;
        uo_out[UO_BL]    = bl_drive;
        uo_out[UO_BUSY]  = (state_q != ST_IDLE);
        uo_out[UO_RDV]   = rdv_q;
        uo_out[UO_RDATA] = rdata_q;
        uo_out[UO_DROP]  = dropped_q;
    end

    assign uio_out = wordline;
    assign uio_oe  = 8'hFF;

`ifdef RAM_CTRL_SENSE_VOTE_EN
    logic [1:0] vote_q;

    // Holds the two samples preceding the final SENSE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_q <= '0;
        end else if (state_q == ST_SENSE) begin
            vote_q <= {vote_q[0], sense_q};
        end
    end

    assign rdata_next = majority3(vote_q[1], vote_q[0], sense_q);
`else
    assign rdata_next = sense_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            wdata_q   <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= 1'b0;
            rdv_q     <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            rdv_q <= sense_last;
            if (sense_last) begin
                rdata_q <= rdata_next;
            end
            if (accept) begin
                we_q      <= cmd_sync[UI_WE];
                wdata_q   <= cmd_sync[UI_WDATA];
                addr_q    <= cmd_sync[UI_ADDR_H:UI_ADDR_L];
                dropped_q <= 1'b0;
            end else if (start_rise && ena && (state_q != ST_IDLE)) begin
                dropped_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_ram_ctrl_seq.sv
// Scoreboard bench for tt_ram_ctrl_seq: each issued command pushes an expected
// operation summary; a monitor rebuilds the observed summary when busy falls.
module tb_tt_ram_ctrl_seq;

    localparam int T_PRE   = 4;
    localparam int T_WL    = 2;
    localparam int T_SENSE = 4;
    localparam int T_WR    = 4;
    localparam int T_REC   = 1;
    localparam int RD_BUSY = T_PRE + T_WL + T_SENSE + T_REC;
    localparam int WR_BUSY = T_PRE + T_WR + T_REC;
    // Index of the ui_in[6] value (cycles after start was first sampled) that
    // reaches the synchroniser output on the final SENSE cycle.
    localparam int SENSE_IDX = T_PRE + T_WL + T_SENSE;

    typedef struct packed {
        logic [7:0] busy_len;
        logic [7:0] pre_len;
        logic [7:0] wl_len;
        logic [7:0] wl_val;
        logic [7:0] sense_len;
        logic [7:0] wr_len;
        logic [7:0] bl_len;
        logic [3:0] rdv_cnt;
        logic       rdata;
        logic       drop_first;
        logic       drop_last;
    } rec_t;
    localparam int W = $bits(rec_t);

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic last_rdata = 1'b0;

    tt_ram_ctrl_seq #(
        .T_PRE(T_PRE), .T_WL(T_WL), .T_SENSE(T_SENSE), .T_WR(T_WR), .T_REC(T_REC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_rdata(input logic [31:0] pat);
        int votes;
`ifdef RAM_CTRL_SENSE_VOTE_EN
        votes = int'(pat[SENSE_IDX-2]) + int'(pat[SENSE_IDX-1]) + int'(pat[SENSE_IDX]);
        return votes >= 2;
`else
        votes = 0;
        return pat[SENSE_IDX];
`endif
    endfunction

    // Driver: one command; called and returns at posedge+1.
    task automatic do_cmd(input logic we, input logic wd, input logic [2:0] addr,
                          input logic [31:0] pat, input int extra_at, input int ena_off_at);
        int   busy;
        rec_t e;
        logic sticky;
        busy = we ? WR_BUSY : RD_BUSY;
        e = '0;
        e.busy_len = 8'(busy);
        e.pre_len  = 8'(T_PRE);
        e.wl_val   = 8'd1 << addr;
        if (we) begin
            e.wl_len = 8'(T_WR);
            e.wr_len = 8'(T_WR);
            e.bl_len = wd ? 8'(T_WR) : 8'd0;
        end else begin
            e.wl_len    = 8'(T_WL + T_SENSE);
            e.sense_len = 8'(T_SENSE);
            e.rdv_cnt   = 4'd1;
            last_rdata  = model_rdata(pat);
        end
        e.rdata      = last_rdata;
        e.drop_first = 1'b0;
        // A second start is seen two cycles after it is sampled; it is dropped
        // up to and including the return-to-idle edge.
        e.drop_last  = (extra_at >= 3) && (extra_at <= busy - 1);
        sticky       = (extra_at >= 3) && (extra_at <= busy);
        exp_q.push_back(W'(e));
        for (int j = 0; j <= busy + 6; j++) begin
            ui_in[0]   = (j < 2) || (extra_at != 0 && (j == extra_at || j == extra_at + 1));
            ui_in[1]   = we;
            ui_in[2]   = wd;
            ui_in[5:3] = addr;
            ui_in[6]   = pat[(j < 32) ? j : 31];
            ena        = !(ena_off_at != 0 && j >= ena_off_at);
            @(posedge clk);
            #1;
        end
        ena = 1'b1;
        check("cmd_dropped_after_op", uo_out[7], sticky);
    endtask

    // Monitor / scoreboard
    logic in_op = 1'b0;
    rec_t act;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_op = 1'b0;
        end else begin
            check("drive_rules",
                  {(uo_out[0] && uio_out != 0), (uo_out[1] && uo_out[2]),
                   ((uio_out & (uio_out - 8'd1)) != 0), (uo_out[5] && !uo_out[4]), uio_oe},
                  {4'b0000, 8'hFF});
            if (uo_out[4]) begin
                if (!in_op) begin
                    in_op = 1'b1;
                    act = '0;
                    act.drop_first = uo_out[7];
                end
                act.busy_len = act.busy_len + 8'd1;
                if (uo_out[0]) act.pre_len = act.pre_len + 8'd1;
                if (uio_out != 0) act.wl_len = act.wl_len + 8'd1;
                act.wl_val = act.wl_val | uio_out;
                if (uo_out[1]) act.sense_len = act.sense_len + 8'd1;
                if (uo_out[2]) act.wr_len = act.wr_len + 8'd1;
                if (uo_out[3]) act.bl_len = act.bl_len + 8'd1;
                if (uo_out[5]) act.rdv_cnt = act.rdv_cnt + 4'd1;
                act.rdata     = uo_out[6];
                act.drop_last = uo_out[7];
            end else if (in_op) begin
                in_op = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_op", 1, 0);
                end else begin
                    check("op_summary", 64'(act), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [31:0] pat;
        logic        we, wd;
        logic [2:0]  addr;
        int          busy, extra, eoff;

        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = '0;
        uio_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_uo_out", uo_out, 8'h00);
        check("post_reset_uio_out", uio_out, 8'h00);
        check("post_reset_uio_oe", uio_oe, 8'hFF);

        // Directed write and read
        do_cmd(1'b1, 1'b1, 3'd5, 32'h0, 0, 0);
        do_cmd(1'b0, 1'b0, 3'd2, 32'hFFFF_FFFF, 0, 0);
        // Vote patterns on the last three sense samples: 1,0,1 then 1,1,0
        pat = '0;
        pat[SENSE_IDX-2] = 1'b1;
        pat[SENSE_IDX]   = 1'b1;
        do_cmd(1'b0, 1'b0, 3'd7, pat, 0, 0);
        pat = '0;
        pat[SENSE_IDX-2] = 1'b1;
        pat[SENSE_IDX-1] = 1'b1;
        do_cmd(1'b0, 1'b0, 3'd0, pat, 0, 0);
        // Dropped start three cycles into a read, then cleared by the next command
        do_cmd(1'b0, 1'b1, 3'd4, 32'hFFFF_FFFF, 3, 0);
        do_cmd(1'b1, 1'b0, 3'd1, 32'h0, 0, 0);
        // Start landing on the return-to-idle edge is dropped
        do_cmd(1'b1, 1'b1, 3'd6, 32'h0, WR_BUSY, 0);
        // ena low mid-operation: operation completes
        do_cmd(1'b0, 1'b0, 3'd3, 32'hFFFF_FFFF, 0, 4);

        // Start with ena low is ignored
        ena = 1'b0;
        for (int j = 0; j < 16; j++) begin
            ui_in[0] = (j < 2);
            @(posedge clk);
            #1;
        end
        check("ena_low_ignored_busy", uo_out[4], 1'b0);
        ena = 1'b1;

        // Reset during SENSE
        ui_in[5:1] = {3'd3, 1'b0, 1'b0};
        ui_in[6]   = 1'b1;
        for (int j = 0; j < T_PRE + T_WL + 4; j++) begin
            ui_in[0] = (j < 2);
            @(posedge clk);
            #1;
        end
        #1;
        check("mid_sense_sense_en", uo_out[1], 1'b1);
        check("mid_sense_wordline", uio_out, 8'h08);
        rst_n = 1'b0;
        #1;
        check("async_reset_uo_out", uo_out, 8'h00);
        check("async_reset_uio_out", uio_out, 8'h00);
        last_rdata = 1'b0;
        ui_in[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            check("post_abort_idle", uo_out, 8'h00);
        end

        // Randomised commands
        for (int n = 0; n < 40; n++) begin
            we    = 1'($urandom_range(0, 1));
            wd    = 1'($urandom_range(0, 1));
            addr  = 3'($urandom_range(0, 7));
            pat   = $urandom;
            busy  = we ? WR_BUSY : RD_BUSY;
            extra = 0;
            eoff  = 0;
            if ($urandom_range(0, 3) == 0) begin
                extra = $urandom_range(3, busy);
            end else if ($urandom_range(0, 4) == 0) begin
                eoff = $urandom_range(3, busy + 3);
            end
            do_cmd(we, wd, addr, pat, extra, eoff);
        end

        repeat (5) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
